// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
package stopwatch_pkg;

    localparam int unsigned TENTH_W = 4;
    localparam int unsigned SEC_W   = 6;

    localparam int unsigned TENTH_MAX_DEF      = 9;
    localparam int unsigned SEC_MAX_DEF        = 59;
    localparam int unsigned LAP_HOLD_TICKS_DEF = 20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        PAUSE    = 2'd2,
        LAP_SHOW = 2'd3
    } state_e;

endpackage

// File: rtl/time_counter.sv
// Cascaded tenth/second counter: zero has priority over inc, 59.9 wraps to 00.0.
module time_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TENTH_MAX = TENTH_MAX_DEF,
    parameter int unsigned SEC_MAX   = SEC_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_i,
    input  logic               zero_i,
    output logic [TENTH_W-1:0] tenth_o,
    output logic [SEC_W-1:0]   sec_o
);

    logic [TENTH_W-1:0] tenth_q, tenth_d;
    logic [SEC_W-1:0]   sec_q,   sec_d;

    // Next count: clear, hold, or increment with tenth->second carry.
    always_comb begin
        tenth_d = tenth_q;
        sec_d   = sec_q;
        if (zero_i) begin
            tenth_d = '0;
            sec_d   = '0;
        end else if (inc_i) begin
            if (tenth_q == TENTH_W'(TENTH_MAX)) begin
                tenth_d = '0;
                if (sec_q == SEC_W'(SEC_MAX)) begin
                    sec_d = '0;
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end else begin
                tenth_d = tenth_q + TENTH_W'(1);
            end
        end
    end

    // Count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tenth_q <= '0;
            sec_q   <= '0;
        end else begin
            tenth_q <= tenth_d;
            sec_q   <= sec_d;
        end
    end

    assign tenth_o = tenth_q;
    assign sec_o   = sec_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button decode, lap display hold and live time counting.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TENTH_MAX      = TENTH_MAX_DEF,
    parameter int unsigned SEC_MAX        = SEC_MAX_DEF,
    parameter int unsigned LAP_HOLD_TICKS = LAP_HOLD_TICKS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start_stop,
    input  logic               lap,
    input  logic               clear,
    output logic [TENTH_W-1:0] tenth_sec_cnt,
    output logic [SEC_W-1:0]   sec_cnt,
    output logic               lap_en,
    output logic               lap_clr,
    output logic               disp_sel_lap,
    output logic               running
);

    localparam int unsigned HOLD_W = $clog2(LAP_HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(LAP_HOLD_TICKS - 1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                lap_en_q, lap_en_d;
    logic                lap_clr_q, lap_clr_d;
    logic                disp_q, disp_d;
    logic                running_q, running_d;
    logic                cnt_inc;
    logic                cnt_zero;

    // Event decode per state; illegal events fall through to lower-priority ones.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        lap_en_d  = 1'b0;
        lap_clr_d = 1'b0;
        cnt_inc   = 1'b0;
        cnt_zero  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    lap_clr_d = 1'b1;
                end else if (start_stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (start_stop) begin
                    state_d = PAUSE;
                end else begin
                    cnt_inc = tick;
                    if (lap) begin
                        state_d  = LAP_SHOW;
                        lap_en_d = 1'b1;
                        hold_d   = HOLD_RELOAD;
                    end
                end
            end
            LAP_SHOW: begin
                if (start_stop) begin
                    state_d = PAUSE;
                end else begin
                    cnt_inc = tick;
                    if (lap) begin
                        lap_en_d = 1'b1;
                        hold_d   = HOLD_RELOAD;
                    end else if (tick) begin
                        if (hold_q == '0) begin
                            state_d = RUN;
                        end else begin
                            hold_d = hold_q - HOLD_W'(1);
                        end
                    end
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_d   = IDLE;
                    cnt_zero  = 1'b1;
                    lap_clr_d = 1'b1;
                end else if (start_stop) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        disp_d    = (state_d == LAP_SHOW);
        running_d = (state_d == RUN) || (state_d == LAP_SHOW);
    end

    // State, hold counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            lap_en_q  <= 1'b0;
            lap_clr_q <= 1'b0;
            disp_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            lap_en_q  <= lap_en_d;
            lap_clr_q <= lap_clr_d;
            disp_q    <= disp_d;
            running_q <= running_d;
        end
    end

    time_counter #(
        .TENTH_MAX (TENTH_MAX),
        .SEC_MAX   (SEC_MAX)
    ) u_time_counter (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (cnt_inc),
        .zero_i  (cnt_zero),
        .tenth_o (tenth_sec_cnt),
        .sec_o   (sec_cnt)
    );

    assign lap_en       = lap_en_q;
    assign lap_clr      = lap_clr_q;
    assign disp_sel_lap = disp_q;
    assign running      = running_q;

endmodule
